// File: rtl/rf_multiport.sv
// Multi-read, dual write-back register file with a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rf_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] idu_rf_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rf_idu_rd_data,
  output logic [NUM_RD-1:0]        rf_idu_rd_busy,
  input  logic                     lsu_rf_wb_vld,
  input  logic [ADDR_W-1:0]        lsu_rf_wb_addr,
  input  logic [DATA_W-1:0]        lsu_rf_wb_data,
  input  logic                     alu_rf_wb_vld,
  input  logic [ADDR_W-1:0]        alu_rf_wb_addr,
  input  logic [DATA_W-1:0]        alu_rf_wb_data,
  input  logic                     idu_rf_busy_set_vld,
  input  logic [ADDR_W-1:0]        idu_rf_busy_set_addr,
  output logic                     rf_idu_busy_set_rdy,
  input  logic                     idu_rf_flush,
  output logic [ADDR_W:0]          rf_idu_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [DEPTH-1:0]  w_wr_en;
  logic [DEPTH-1:0]  w_wr_sel_lsu;
  logic [DEPTH-1:0]  w_busy_next;
  logic [ADDR_W:0]   w_cnt_next;
  logic              w_lsu_wr_ok;
  logic              w_alu_wr_ok;
  logic              w_set_wr_hit;
  logic              w_set_rdy;
  logic              w_set_acc;

  // Entry 0 never sees a write enable, so it stays at its reset value of zero.
  assign w_lsu_wr_ok = lsu_rf_wb_vld & (lsu_rf_wb_addr != '0);
  assign w_alu_wr_ok = alu_rf_wb_vld & (alu_rf_wb_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr
      if (gi == 0) begin : g_zero
        assign w_wr_en[gi]      = 1'b0;
        assign w_wr_sel_lsu[gi] = 1'b0;
      end else begin : g_ent
        assign w_wr_sel_lsu[gi] = lsu_rf_wb_vld & (lsu_rf_wb_addr == ADDR_W'(gi));
        assign w_wr_en[gi]      = w_wr_sel_lsu[gi] |
                                  (alu_rf_wb_vld & (alu_rf_wb_addr == ADDR_W'(gi)));
      end
    end
  endgenerate

  assign w_set_wr_hit = (w_lsu_wr_ok & (lsu_rf_wb_addr == idu_rf_busy_set_addr)) |
                        (w_alu_wr_ok & (alu_rf_wb_addr == idu_rf_busy_set_addr));
  assign w_set_rdy    = (idu_rf_busy_set_addr == '0) | ~r_busy[idu_rf_busy_set_addr] |
                        w_set_wr_hit;
  assign w_set_acc    = idu_rf_busy_set_vld & w_set_rdy & ~idu_rf_flush &
                        (idu_rf_busy_set_addr != '0);

  // Priority, lowest to highest: hold, clear-on-write, set, flush.
  always_comb begin
    w_busy_next = r_busy & ~w_wr_en;
    if (w_set_acc)
      w_busy_next[idu_rf_busy_set_addr] = 1'b1;
    if (idu_rf_flush)
      w_busy_next = '0;
    w_cnt_next = '0;
    for (int i = 1; i < DEPTH; i++)
      w_cnt_next = w_cnt_next + (ADDR_W+1)'(w_busy_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (w_wr_en[i])
          r_regs[i] <= w_wr_sel_lsu[i] ? lsu_rf_wb_data : alu_rf_wb_data;
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_rd_addr;
      assign w_rd_addr = idu_rf_rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      logic w_lsu_hit;
      logic w_alu_hit;
      assign w_lsu_hit = w_lsu_wr_ok & (lsu_rf_wb_addr == w_rd_addr);
      assign w_alu_hit = w_alu_wr_ok & (alu_rf_wb_addr == w_rd_addr);
      assign rf_idu_rd_data[gi*DATA_W +: DATA_W] = w_lsu_hit ? lsu_rf_wb_data :
                                                   w_alu_hit ? alu_rf_wb_data :
                                                   r_regs[w_rd_addr];
      assign rf_idu_rd_busy[gi] = r_busy[w_rd_addr] & ~(w_lsu_hit | w_alu_hit);
`else
      assign rf_idu_rd_data[gi*DATA_W +: DATA_W] = r_regs[w_rd_addr];
      assign rf_idu_rd_busy[gi] = r_busy[w_rd_addr];
`endif
    end
  endgenerate

  assign rf_idu_busy_set_rdy = w_set_rdy;
  assign rf_idu_busy_cnt     = r_busy_cnt;

endmodule

// File: tb/tb_rf_multiport.sv
// Directed plus randomized bench for rf_multiport against an array/scoreboard reference model.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr;
  wire  [63:0] rd_data;
  wire  [1:0]  rd_busy;
  logic        lsu_vld;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        alu_vld;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        set_vld;
  logic [4:0]  set_addr;
  wire         set_rdy;
  logic        flush;
  wire  [5:0]  busy_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .idu_rf_rd_addr       (rd_addr),
    .rf_idu_rd_data       (rd_data),
    .rf_idu_rd_busy       (rd_busy),
    .lsu_rf_wb_vld        (lsu_vld),
    .lsu_rf_wb_addr       (lsu_addr),
    .lsu_rf_wb_data       (lsu_data),
    .alu_rf_wb_vld        (alu_vld),
    .alu_rf_wb_addr       (alu_addr),
    .alu_rf_wb_data       (alu_data),
    .idu_rf_busy_set_vld  (set_vld),
    .idu_rf_busy_set_addr (set_addr),
    .rf_idu_busy_set_rdy  (set_rdy),
    .idu_rf_flush         (flush),
    .rf_idu_busy_cnt      (busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
`ifdef RF_BYPASS_EN
    if (a != 0 && lsu_vld && lsu_addr == a) return lsu_data;
    if (a != 0 && alu_vld && alu_addr == a) return alu_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
`ifdef RF_BYPASS_EN
    if (a != 0 && ((lsu_vld && lsu_addr == a) || (alu_vld && alu_addr == a))) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic exp_rdy();
    if (set_addr == 0 || !m_busy[set_addr]) return 1'b1;
    return (lsu_vld && lsu_addr == set_addr) || (alu_vld && alu_addr == set_addr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Applies the inputs held across the edge to the model: ALU first so an LSU write to the same entry wins.
  task automatic model_step();
    logic rdy;
    rdy = exp_rdy();
    if (alu_vld && alu_addr != 0) begin
      m_mem[alu_addr]  = alu_data;
      m_busy[alu_addr] = 1'b0;
    end
    if (lsu_vld && lsu_addr != 0) begin
      m_mem[lsu_addr]  = lsu_data;
      m_busy[lsu_addr] = 1'b0;
    end
    if (set_vld && rdy && !flush && set_addr != 0) m_busy[set_addr] = 1'b1;
    if (flush)
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      chk({tag, "_data"}, 64'(rd_data[k*32 +: 32]), 64'(exp_data(a)));
      chk({tag, "_busy"}, 64'(rd_busy[k]), 64'(exp_busy(a)));
    end
    chk({tag, "_rdy"}, 64'(set_rdy), 64'(exp_rdy()));
    chk({tag, "_cnt"}, 64'(busy_cnt), 64'(exp_cnt()));
    $display("txn %s rd=%h/%h data=%h busy=%b rdy=%b cnt=%0d", tag,
             rd_addr[4:0], rd_addr[9:5], rd_data, rd_busy, set_rdy, busy_cnt);
  endtask

  task automatic idle();
    lsu_vld = 0; lsu_addr = 0; lsu_data = 0;
    alu_vld = 0; alu_addr = 0; alu_data = 0;
    set_vld = 0; set_addr = 0; flush = 0;
  endtask

  task automatic cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      cycle("rd_all");
    end

    // Dual write in one cycle, then read back
    lsu_vld = 1; lsu_addr = 5; lsu_data = 32'hDEADBEEF;
    alu_vld = 1; alu_addr = 6; alu_data = 32'h12345678;
    rd_addr = {5'd6, 5'd5};
    cycle("wr56");
    idle();
    #1;
    chk("x5", 64'(rd_data[31:0]), 64'h00000000DEADBEEF);
    chk("x6", 64'(rd_data[63:32]), 64'h0000000012345678);
    cycle("rd56");

    lsu_vld = 1; lsu_addr = 0; lsu_data = 32'hFFFFFFFF;
    rd_addr = '0;
    cycle("wr_x0");
    idle();
    #1;
    chk("x0", 64'(rd_data), 64'h0);
    cycle("rd_x0");

    // Same-address conflict: LSU wins
    lsu_vld = 1; lsu_addr = 7; lsu_data = 32'hAAAA0000;
    alu_vld = 1; alu_addr = 7; alu_data = 32'h5555FFFF;
    rd_addr = {5'd7, 5'd7};
    cycle("wr7");
    idle();
    #1;
    chk("x7", 64'(rd_data[31:0]), 64'h00000000AAAA0000);
    cycle("rd7");

    // Busy handshake on x9
    set_vld = 1; set_addr = 9; rd_addr = {5'd9, 5'd9};
    cycle("set9");
    #1;
    chk("x9_cnt1", 64'(busy_cnt), 64'd1);
    chk("x9_busy", 64'(rd_busy), 64'b11);
    chk("x9_rdy0", 64'(set_rdy), 64'd0);
    cycle("set9_stall");
    alu_vld = 1; alu_addr = 9; alu_data = 32'h00000099;
    #1;
    chk("x9_rdy_wr", 64'(set_rdy), 64'd1);
    cycle("set9_wr");
    idle();
    #1;
    chk("x9_cnt_keep", 64'(busy_cnt), 64'd1);
    chk("x9_busy_keep", 64'(rd_busy), 64'b11);
    cycle("x9_after");

    // Set three entries, then flush alongside a fourth set
    for (int a = 1; a <= 3; a++) begin
      set_vld = 1; set_addr = 5'(a); rd_addr = {5'(a), 5'(a)};
      cycle("set_n");
    end
    set_vld = 1; set_addr = 4; flush = 1; rd_addr = {5'd4, 5'd1};
    cycle("flush");
    idle();
    #1;
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    cycle("post_flush");

    // Asynchronous reset mid-sequence
    set_vld = 1; set_addr = 5; cycle("pre_rst_a");
    set_vld = 1; set_addr = 6; cycle("pre_rst_b");
    idle();
    rd_addr = {5'd6, 5'd5};
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_async_data", 64'(rd_data), 64'd0);
    check_all("rst_async");
    @(posedge clk); #1;
    rst = 1'b0;

    // Same-cycle write/read of x10
    lsu_vld = 1; lsu_addr = 10; lsu_data = 32'h00001111; rd_addr = {5'd10, 5'd10};
    cycle("x10_init");
    lsu_vld = 1; lsu_addr = 10; lsu_data = 32'h0000CAFE;
    #1;
`ifdef RF_BYPASS_EN
    chk("x10_same", 64'(rd_data[31:0]), 64'h000000000000CAFE);
`else
    chk("x10_same", 64'(rd_data[31:0]), 64'h0000000000001111);
`endif
    cycle("x10_wr");
    idle();
    #1;
    chk("x10_next", 64'(rd_data[31:0]), 64'h000000000000CAFE);
    cycle("x10_rd");

    // Randomized traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      lsu_vld  = ($urandom_range(0, 2) == 0);
      lsu_addr = 5'($urandom_range(0, 11));
      lsu_data = $urandom;
      alu_vld  = ($urandom_range(0, 2) == 0);
      alu_addr = 5'($urandom_range(0, 11));
      alu_data = $urandom;
      set_vld  = ($urandom_range(0, 1) == 0);
      set_addr = 5'($urandom_range(0, 11));
      flush    = ($urandom_range(0, 24) == 0);
      rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
